phy_rx_lane_ctrl: RTL and testbench

- Two-lane receive link controller between the per-lane serial-to-parallel converters and the 8b-to-32b/un-striping stages.
- Locks each lane on the COM symbol (8'hBC) and measures inter-lane skew at the end of the COM burst.
- Deskews the leading lane through a tapped delay line and gates aligned bytes downstream only while the link is up.
- Detects loss of lane or valid mismatch and retrains.

---
 rtl/phy_rx_pkg.sv | 46 ++++
 rtl/phy_rx_lane_delay.sv | 47 ++++
 rtl/phy_rx_lane_ctrl.sv | 178 +++++++++++++++++
 tb/tb_phy_rx_lane_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// Shared constants, state encoding and lane byte payload for the two-lane receive controller.
package phy_rx_pkg;

    localparam logic [7:0]  COM       = 8'hBC;
    localparam int unsigned LOCK_CNT  = 4;
    localparam int unsigned MAX_SKEW  = 3;
    localparam int unsigned LOSS_CNT  = 8;
    localparam int unsigned ERR_MAX   = 4;

    localparam int unsigned LOCK_W    = 3;
    localparam int unsigned SKEW_W    = 3;
    localparam int unsigned LOSS_W    = 4;
    localparam int unsigned ERR_W     = 3;
    localparam int unsigned LANE_W    = 9;
    localparam int unsigned DLY_DEPTH = MAX_SKEW + 1;
    localparam int unsigned TAP_W     = $clog2(DLY_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_DESKEW = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } lane_byte_t;

    // Saturating COM run counter; a non-COM valid byte restarts the run.
    function automatic logic [LOCK_W-1:0] lock_next(input logic [LOCK_W-1:0] cnt,
                                                    input logic              valid,
                                                    input logic [7:0]        data);
        logic [LOCK_W-1:0] res;
        res = cnt;
        if (valid) begin
            if (data != COM) begin
                res = '0;
            end else if (cnt != LOCK_W'(LOCK_CNT)) begin
                res = cnt + LOCK_W'(1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/phy_rx_lane_delay.sv
// Per-lane {valid,data} delay line; tap k presents the byte from k cycles ago through the output register.
module phy_rx_lane_delay
    import phy_rx_pkg::*;
#(
    parameter int unsigned DEPTH = DLY_DEPTH,
    parameter int unsigned TW    = TAP_W
) (
    input  logic              clock4,
    input  logic              reset,
    input  logic              en_i,
    input  logic [TW-1:0]     tap_i,
    input  logic [LANE_W-1:0] in_i,
    output logic [LANE_W-1:0] out_o
);

    lane_byte_t sr_q [DEPTH-1];
    lane_byte_t tap_c;
    lane_byte_t out_q;

    // Tap 0 bypasses the shift stages and goes straight into the output register.
    always_comb begin
        tap_c = in_i;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (tap_i == TW'(k)) begin
                tap_c = sr_q[k-1];
            end
        end
    end

    always_ff @(posedge clock4 or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH-1; k++) begin
                sr_q[k] <= '0;
            end
            out_q <= '0;
        end else begin
            sr_q[0] <= in_i;
            for (int unsigned k = 1; k < DEPTH-1; k++) begin
                sr_q[k] <= sr_q[k-1];
            end
            out_q <= en_i ? tap_c : '0;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/phy_rx_lane_ctrl.sv
// Two-lane receive link controller: COM lock, skew measurement, deskew and link supervision.
module phy_rx_lane_ctrl
    import phy_rx_pkg::*;
(
    input  logic       clock4,
    input  logic       reset,
    input  logic       enable,
    input  logic       valid_0,
    input  logic [7:0] data_0,
    input  logic       valid_1,
    input  logic [7:0] data_1,
    output logic [7:0] data_out_0,
    output logic       valid_out_0,
    output logic [7:0] data_out_1,
    output logic       valid_out_1,
    output logic       link_up,
    output logic [1:0] state,
    output logic [2:0] skew,
    output logic       lead_lane,
    output logic [7:0] retrain_cnt
);

    state_e            state_q, state_d;
    logic [LOCK_W-1:0] lock0_q, lock0_d, lock1_q, lock1_d;
    logic              arr0_q, arr0_d, arr1_q, arr1_d;
    logic [SKEW_W-1:0] cnt_q, cnt_d, skew_q, skew_d;
    logic              lead_q, lead_d;
    logic [LOSS_W-1:0] loss0_q, loss0_d, loss1_q, loss1_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [7:0]        retrain_q;
    logic              link_q;
    logic              hit0_c, hit1_c, act_en_c;
    logic [TAP_W-1:0]  tap0_c, tap1_c;
    lane_byte_t        dly0, dly1;

    assign hit0_c = valid_0 && (data_0 != COM);
    assign hit1_c = valid_1 && (data_1 != COM);

    always_comb begin
        state_d = state_q;
        lock0_d = lock0_q;
        lock1_d = lock1_q;
        arr0_d  = arr0_q;
        arr1_d  = arr1_q;
        cnt_d   = cnt_q;
        skew_d  = skew_q;
        lead_d  = lead_q;
        loss0_d = loss0_q;
        loss1_d = loss1_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: state_d = ST_SYNC;
            ST_SYNC: begin
                lock0_d = lock_next(lock0_q, valid_0, data_0);
                lock1_d = lock_next(lock1_q, valid_1, data_1);
                if (lock0_d == LOCK_W'(LOCK_CNT) && lock1_d == LOCK_W'(LOCK_CNT)) begin
                    state_d = ST_DESKEW;
                end
            end
            ST_DESKEW: begin
                arr0_d = arr0_q | hit0_c;
                arr1_d = arr1_q | hit1_c;
                // cnt_q is the number of cycles since the first lane's payload arrived.
                if (arr0_q != arr1_q) begin
                    if (cnt_q > SKEW_W'(MAX_SKEW)) begin
                        state_d = ST_IDLE;
                    end else if (arr0_q ? hit1_c : hit0_c) begin
                        skew_d  = cnt_q;
                        lead_d  = arr1_q;
                        state_d = ST_ACTIVE;
                    end else begin
                        cnt_d = cnt_q + SKEW_W'(1);
                    end
                end else if (hit0_c && hit1_c) begin
                    skew_d  = '0;
                    lead_d  = 1'b0;
                    state_d = ST_ACTIVE;
                end else if (hit0_c || hit1_c) begin
                    cnt_d = SKEW_W'(1);
                end
            end
            ST_ACTIVE: begin
                loss0_d = valid_0 ? '0 : loss0_q + LOSS_W'(1);
                loss1_d = valid_1 ? '0 : loss1_q + LOSS_W'(1);
                err_d   = err_q + ERR_W'(dly0.valid != dly1.valid);
                if (loss0_d == LOSS_W'(LOSS_CNT) || loss1_d == LOSS_W'(LOSS_CNT) ||
                    err_d == ERR_W'(ERR_MAX)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
        end
    end

    // The leading lane waits skew extra cycles; next-state values let the first ACTIVE cycle align.
    assign act_en_c = (state_d == ST_ACTIVE);
    assign tap0_c   = lead_d ? '0 : TAP_W'(skew_d);
    assign tap1_c   = lead_d ? TAP_W'(skew_d) : '0;

    always_ff @(posedge clock4 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lock0_q   <= '0;
            lock1_q   <= '0;
            arr0_q    <= 1'b0;
            arr1_q    <= 1'b0;
            cnt_q     <= '0;
            skew_q    <= '0;
            lead_q    <= 1'b0;
            loss0_q   <= '0;
            loss1_q   <= '0;
            err_q     <= '0;
            retrain_q <= '0;
            link_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            link_q  <= act_en_c;
            if (state_q != ST_IDLE && state_d == ST_IDLE && retrain_q != 8'hFF) begin
                retrain_q <= retrain_q + 8'd1;
            end
            if (state_d == ST_IDLE) begin
                lock0_q <= '0;
                lock1_q <= '0;
                arr0_q  <= 1'b0;
                arr1_q  <= 1'b0;
                cnt_q   <= '0;
                skew_q  <= '0;
                lead_q  <= 1'b0;
                loss0_q <= '0;
                loss1_q <= '0;
                err_q   <= '0;
            end else begin
                lock0_q <= lock0_d;
                lock1_q <= lock1_d;
                arr0_q  <= arr0_d;
                arr1_q  <= arr1_d;
                cnt_q   <= cnt_d;
                skew_q  <= skew_d;
                lead_q  <= lead_d;
                loss0_q <= loss0_d;
                loss1_q <= loss1_d;
                err_q   <= err_d;
            end
        end
    end

    phy_rx_lane_delay #(.DEPTH(DLY_DEPTH), .TW(TAP_W)) u_dly0 (
        .clock4 (clock4),
        .reset  (reset),
        .en_i   (act_en_c),
        .tap_i  (tap0_c),
        .in_i   ({valid_0, data_0}),
        .out_o  (dly0)
    );

    phy_rx_lane_delay #(.DEPTH(DLY_DEPTH), .TW(TAP_W)) u_dly1 (
        .clock4 (clock4),
        .reset  (reset),
        .en_i   (act_en_c),
        .tap_i  (tap1_c),
        .in_i   ({valid_1, data_1}),
        .out_o  (dly1)
    );

    assign data_out_0  = dly0.data;
    assign valid_out_0 = dly0.valid;
    assign data_out_1  = dly1.data;
    assign valid_out_1 = dly1.valid;
    assign link_up     = link_q;
    assign state       = state_q;
    assign skew        = skew_q;
    assign lead_lane   = lead_q;
    assign retrain_cnt = retrain_q;

endmodule

// File: tb/tb_phy_rx_lane_ctrl.sv
// Randomized bench for phy_rx_lane_ctrl against a cycle-history reference model of the link rules.
module tb_phy_rx_lane_ctrl;

    localparam logic [7:0] K_COM  = 8'hBC;
    localparam int         K_LOCK = 4;
    localparam int         K_SKEW = 3;
    localparam int         K_LOSS = 8;
    localparam int         K_ERR  = 4;

    logic       clock4 = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       valid_0 = 1'b0, valid_1 = 1'b0;
    logic [7:0] data_0 = 8'h00, data_1 = 8'h00;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1, link_up, lead_lane;
    logic [1:0] state;
    logic [2:0] skew;
    logic [7:0] retrain_cnt;

    int n_chk = 0;
    int n_err = 0;
    bit seen_link;

    // Reference model: phase, counters and a history of every byte each lane delivered.
    int         m_st, m_first, m_skew, m_lead, m_err, m_rt, cyc;
    int         m_lock [2];
    int         m_loss [2];
    bit         m_arr  [2];
    logic [8:0] hist0 [16];
    logic [8:0] hist1 [16];
    logic [8:0] e_o0, e_o1;

    phy_rx_lane_ctrl dut (
        .clock4      (clock4),
        .reset       (reset),
        .enable      (enable),
        .valid_0     (valid_0),
        .data_0      (data_0),
        .valid_1     (valid_1),
        .data_1      (data_1),
        .data_out_0  (data_out_0),
        .valid_out_0 (valid_out_0),
        .data_out_1  (data_out_1),
        .valid_out_1 (valid_out_1),
        .link_up     (link_up),
        .state       (state),
        .skew        (skew),
        .lead_lane   (lead_lane),
        .retrain_cnt (retrain_cnt)
    );

    always #5 clock4 = ~clock4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_first = 0; m_skew = 0; m_lead = 0; m_err = 0; m_rt = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            m_lock[i] = 0; m_loss[i] = 0; m_arr[i] = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            hist0[i] = '0; hist1[i] = '0;
        end
        e_o0 = '0; e_o1 = '0;
    endtask

    task automatic m_step(input bit en, input bit v0, input logic [7:0] d0,
                          input bit v1, input logic [7:0] d1);
        int  nx, gap, dl0, dl1;
        bit  h0, h1;
        bit  vv [2];
        logic [7:0] dd [2];
        vv[0] = v0; vv[1] = v1; dd[0] = d0; dd[1] = d1;
        hist0[cyc % 16] = {v0, d0};
        hist1[cyc % 16] = {v1, d1};
        h0 = v0 && (d0 != K_COM);
        h1 = v1 && (d1 != K_COM);
        nx = m_st;
        case (m_st)
            0: nx = 1;
            1: begin
                for (int i = 0; i < 2; i++) begin
                    if (vv[i]) m_lock[i] = (dd[i] == K_COM) ? ((m_lock[i] < K_LOCK) ? m_lock[i] + 1 : K_LOCK) : 0;
                end
                if (m_lock[0] == K_LOCK && m_lock[1] == K_LOCK) nx = 2;
            end
            2: begin
                if (!m_arr[0] && !m_arr[1]) begin
                    if (h0 && h1) begin
                        m_skew = 0; m_lead = 0; nx = 3;
                    end else if (h0 || h1) begin
                        m_arr[0] = h0; m_arr[1] = h1; m_first = cyc;
                    end
                end else begin
                    gap = cyc - m_first;
                    if (gap > K_SKEW) nx = 0;
                    else if (m_arr[0] ? h1 : h0) begin
                        m_skew = gap; m_lead = m_arr[1] ? 1 : 0; nx = 3;
                    end
                end
            end
            default: begin
                m_loss[0] = v0 ? 0 : m_loss[0] + 1;
                m_loss[1] = v1 ? 0 : m_loss[1] + 1;
                if (e_o0[8] != e_o1[8]) m_err++;
                if (m_loss[0] >= K_LOSS || m_loss[1] >= K_LOSS || m_err >= K_ERR) nx = 0;
            end
        endcase
        if (!en) nx = 0;
        if (m_st != 0 && nx == 0 && m_rt < 255) m_rt++;
        if (nx == 0) begin
            for (int i = 0; i < 2; i++) begin
                m_lock[i] = 0; m_loss[i] = 0; m_arr[i] = 1'b0;
            end
            m_skew = 0; m_lead = 0; m_err = 0;
        end
        if (nx == 3) begin
            dl0 = (m_lead == 0) ? m_skew : 0;
            dl1 = (m_lead == 1) ? m_skew : 0;
            e_o0 = hist0[(cyc + 16 - dl0) % 16];
            e_o1 = hist1[(cyc + 16 - dl1) % 16];
        end else begin
            e_o0 = '0; e_o1 = '0;
        end
        m_st = nx;
        cyc++;
    endtask

    task automatic compare_all();
        chk("state", 32'(state), 32'(m_st));
        chk("link_up", 32'(link_up), 32'(m_st == 3));
        chk("skew", 32'(skew), 32'(m_skew));
        chk("lead_lane", 32'(lead_lane), 32'(m_lead));
        chk("retrain_cnt", 32'(retrain_cnt), 32'(m_rt));
        chk("out0", 32'({valid_out_0, data_out_0}), 32'(e_o0));
        chk("out1", 32'({valid_out_1, data_out_1}), 32'(e_o1));
    endtask

    task automatic tick(input bit en, input bit v0, input logic [7:0] d0,
                        input bit v1, input logic [7:0] d1);
        @(negedge clock4);
        compare_all();
        if (link_up === 1'b1) seen_link = 1'b1;
        enable = en; valid_0 = v0; data_0 = d0; valid_1 = v1; data_1 = d1;
        m_step(en, v0, d0, v1, d1);
    endtask

    function automatic logic [7:0] rnd_pay();
        logic [7:0] r;
        r = 8'($urandom);
        if (r == K_COM) r = 8'h5A;
        return r;
    endfunction

    // Async reset pulse between edges; outputs must clear before the next clock.
    task automatic do_reset();
        @(posedge clock4);
        #2;
        reset = 1'b1;
        valid_0 = 1'b0; valid_1 = 1'b0; data_0 = 8'h00; data_1 = 8'h00;
        #1;
        m_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_link", 32'(link_up), 32'd0);
        chk("rst_out", 32'({valid_out_0, data_out_0, valid_out_1, data_out_1}), 32'd0);
        chk("rst_skew", 32'({skew, lead_lane}), 32'd0);
        chk("rst_retrain", 32'(retrain_cnt), 32'd0);
        @(posedge clock4);
        @(posedge clock4);
        #2;
        reset = 1'b0;
    endtask

    task automatic quiesce(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // COM preamble per lane (optional 8'h55 glitch on lane 0), then payload starting 8'h11 / 8'h22.
    task automatic run_link(input int n0, input int n1, input int bad0, input int npay,
                            input int drop_pct, input int en_drop);
        int         total;
        bit         v0, v1;
        logic [7:0] d0, d1;
        total = ((n0 > n1) ? n0 : n1) + npay;
        for (int c = 0; c < total; c++) begin
            if (c < n0) begin
                v0 = 1'b1; d0 = (c == bad0) ? 8'h55 : K_COM;
            end else if (c == n0) begin
                v0 = 1'b1; d0 = 8'h11;
            end else begin
                v0 = ($urandom_range(0, 99) >= drop_pct); d0 = rnd_pay();
            end
            if (c < n1) begin
                v1 = 1'b1; d1 = K_COM;
            end else if (c == n1) begin
                v1 = 1'b1; d1 = 8'h22;
            end else begin
                v1 = ($urandom_range(0, 99) >= drop_pct); d1 = rnd_pay();
            end
            tick(c != en_drop, v0, d0, v1, d1);
        end
    endtask

    initial begin
        int n0, n1, bad;
        m_reset();
        do_reset();

        run_link(6, 6, -1, 12, 0, -1);
        quiesce(2);
        run_link(6, 8, -1, 12, 0, -1);

        do_reset();
        seen_link = 1'b0;
        run_link(10, 6, -1, 12, 0, -1);
        chk("big_skew_no_link", 32'(seen_link), 32'd0);
        chk("big_skew_retrain", 32'(retrain_cnt), 32'd1);

        quiesce(2);
        run_link(8, 8, 2, 10, 0, -1);

        quiesce(2);
        run_link(6, 7, -1, 8, 0, -1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, rnd_pay(), 1'b0, rnd_pay());
        chk("loss_link_down", 32'(link_up), 32'd0);

        quiesce(2);
        run_link(6, 6, -1, 8, 0, -1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, rnd_pay(), 1'b0, rnd_pay());
        chk("mismatch_link_down", 32'(link_up), 32'd0);

        quiesce(2);
        run_link(10, 10, -1, 6, 0, 7);
        quiesce(2);
        run_link(6, 7, -1, 8, 0, -1);
        do_reset();

        for (int it = 0; it < 40; it++) begin
            n0 = int'($urandom_range(4, 9));
            n1 = n0 + int'($urandom_range(0, 8)) - 4;
            if (n1 < 4) n1 = 4;
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
            quiesce(int'($urandom_range(1, 3)));
            run_link(n0, n1, bad, int'($urandom_range(5, 20)), int'($urandom_range(0, 15)), -1);
        end
        quiesce(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
